// File: rtl/lcd_bus_sequencer_pkg.sv
// rtl/lcd_bus_sequencer_pkg.sv - shared types and constants for the LCD bus sequencer
//
// Package lcd_pkg:
//   lcd_state_t        sequencer state encoding
//   LCD_RS_CMD/DATA    register-select levels for command and data words
//   LCD_CMD_MEM_WRITE  panel memory-write command word
//   max_of()           elaboration-time helper used to size the shared timer
package lcd_pkg;

  typedef enum logic [2:0] {
    UNINIT   = 3'd0,
    RST_LOW  = 3'd1,
    RST_WAIT = 3'd2,
    IDLE     = 3'd3,
    SETUP    = 3'd4,
    PULSE    = 3'd5,
    HOLD     = 3'd6
  } lcd_state_t;

  localparam logic        LCD_RS_CMD        = 1'b0;
  localparam logic        LCD_RS_DATA       = 1'b1;
  localparam logic [15:0] LCD_CMD_MEM_WRITE = 16'h002C;

  function automatic int max_of(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/lcd_bus_sequencer_if.sv
// rtl/lcd_bus_sequencer_if.sv - valid/ready write-request channel into the LCD sequencer
//
// Signals:
//   req_valid  request present (master -> slave)
//   req_ready  request accepted when valid & ready (slave -> master)
//   req_rs     0 = command, 1 = pixel/parameter data
//   req_data   16-bit bus word
//   req_rep    number of WR pulses for this word; 0 behaves as 1
interface lcd_bus_sequencer_if #(
  parameter int REP_W = 17
);

  logic             req_valid;
  logic             req_ready;
  logic             req_rs;
  logic [15:0]      req_data;
  logic [REP_W-1:0] req_rep;

  modport master (
    output req_valid,
    output req_rs,
    output req_data,
    output req_rep,
    input  req_ready
  );

  modport slave (
    input  req_valid,
    input  req_rs,
    input  req_data,
    input  req_rep,
    output req_ready
  );

endinterface

// File: rtl/lcd_cycle_timer.sv
// rtl/lcd_cycle_timer.sv - loadable saturating down-counter with a done flag
//
// Ports:
//   clk         clock
//   rst         synchronous active-high reset
//   i_load      load i_load_val this cycle (wins over counting)
//   i_load_val  phase length minus one
//   o_done      count has reached zero (last cycle of the current phase)
module lcd_cycle_timer #(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_load_val,
  output logic             o_done
);

  logic [CNT_W-1:0] r_cnt;

  // Holds at zero instead of wrapping, so a phase never restarts by itself.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign o_done = (r_cnt == '0);

endmodule

// File: rtl/lcd_bus_sequencer.sv
// rtl/lcd_bus_sequencer.sv - 8080-style 16-bit LCD write sequencer with panel reset and word repeat
//
// Ports:
//   HCLK, HRESET   clock, synchronous active-high reset
//   init_start     pulse: start/restart panel reset sequence, aborts any transfer
//   init_done      panel initialised, requests are being served
//   req            request channel (slave side of lcd_bus_sequencer_if)
//   bl_on          backlight enable, registered onto LCD_BL_CTR
//   busy           transfer or init sequence in progress
//   LCD_*          registered panel pins (LCD_RD tied high, write-only)
module lcd_bus_sequencer
  import lcd_pkg::*;
#(
  parameter int WR_SETUP     = 1,
  parameter int WR_PULSE     = 2,
  parameter int WR_HOLD      = 1,
  parameter int RST_LOW_CYC  = 1000,
  parameter int RST_WAIT_CYC = 5000,
  parameter int REP_W        = 17
) (
  input  logic                HCLK,
  input  logic                HRESET,
  input  logic                init_start,
  output logic                init_done,
  lcd_bus_sequencer_if.slave  req,
  input  logic                bl_on,
  output logic                busy,
  output logic                LCD_CS,
  output logic                LCD_RS,
  output logic                LCD_WR,
  output logic                LCD_RD,
  output logic                LCD_RST,
  output logic                LCD_BL_CTR,
  output logic [15:0]         LCD_DATA
);

  localparam int MAX_CYC = max_of(max_of(max_of(WR_SETUP, WR_PULSE), max_of(WR_HOLD, RST_LOW_CYC)),
                                  RST_WAIT_CYC);
  localparam int TMR_W   = $clog2(MAX_CYC) + 1;

  lcd_state_t       r_state;
  lcd_state_t       w_next;
  logic [REP_W-1:0] r_rem;
  logic             w_accept;
  logic             w_tmr_load;
  logic [TMR_W-1:0] w_tmr_val;
  logic             w_tmr_done;

  logic             w_cs_nxt;
  logic             w_wr_nxt;
  logic             w_rst_nxt;
  logic             w_rs_nxt;
  logic [15:0]      w_data_nxt;
  logic             w_init_done_nxt;

  assign req.req_ready = (r_state == IDLE) & ~init_start;
  assign w_accept      = req.req_valid & req.req_ready;
  assign busy          = !(r_state inside {UNINIT, IDLE});
  assign LCD_RD        = 1'b1;

  // State register
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      r_state <= UNINIT;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic; init_start overrides every state
  always_comb begin
    w_next = r_state;
    if (init_start) begin
      w_next = RST_LOW;
    end else begin
      case (r_state)
        UNINIT:   w_next = UNINIT;
        RST_LOW:  if (w_tmr_done) w_next = RST_WAIT;
        RST_WAIT: if (w_tmr_done) w_next = IDLE;
        IDLE:     if (w_accept) w_next = SETUP;
        SETUP:    if (w_tmr_done) w_next = PULSE;
        PULSE:    if (w_tmr_done) w_next = HOLD;
        HOLD: begin
          // Repeats go straight back to PULSE: CS stays low, no new setup phase
          if (w_tmr_done) w_next = (r_rem > REP_W'(1)) ? PULSE : IDLE;
        end
        default:  w_next = UNINIT;
      endcase
    end
  end

  // Every phase entry (including an init restart while already in RST_LOW)
  // reloads the shared timer with the length of the phase being entered.
  assign w_tmr_load = init_start | (w_next != r_state);

  always_comb begin
    w_tmr_val = '0;
    case (w_next)
      RST_LOW:  w_tmr_val = TMR_W'(RST_LOW_CYC - 1);
      RST_WAIT: w_tmr_val = TMR_W'(RST_WAIT_CYC - 1);
      SETUP:    w_tmr_val = TMR_W'(WR_SETUP - 1);
      PULSE:    w_tmr_val = TMR_W'(WR_PULSE - 1);
      HOLD:     w_tmr_val = TMR_W'(WR_HOLD - 1);
      default:  w_tmr_val = '0;
    endcase
  end

  lcd_cycle_timer #(
    .CNT_W (TMR_W)
  ) u_timer (
    .clk        (HCLK),
    .rst        (HRESET),
    .i_load     (w_tmr_load),
    .i_load_val (w_tmr_val),
    .o_done     (w_tmr_done)
  );

  // Remaining WR pulses for the current word
  always_ff @(posedge HCLK) begin
    if (HRESET || init_start) begin
      r_rem <= '0;
    end else if (w_accept) begin
      r_rem <= (req.req_rep == '0) ? REP_W'(1) : req.req_rep;
    end else if ((r_state == HOLD) && w_tmr_done && (r_rem > REP_W'(1))) begin
      r_rem <= r_rem - 1'b1;
    end
  end

  // Output decode from the next state, so registered pins line up with the
  // state they belong to.
  always_comb begin
    w_cs_nxt        = !(w_next inside {SETUP, PULSE, HOLD});
    w_wr_nxt        = (w_next != PULSE);
    w_rst_nxt       = !(w_next inside {UNINIT, RST_LOW});
    w_rs_nxt        = w_accept ? req.req_rs : LCD_RS;
    w_data_nxt      = w_accept ? req.req_data : LCD_DATA;
    w_init_done_nxt = init_done;
    if (init_start) begin
      w_init_done_nxt = 1'b0;
    end else if (w_next == IDLE) begin
      w_init_done_nxt = 1'b1;
    end
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      LCD_CS     <= 1'b1;
      LCD_RS     <= LCD_RS_DATA;
      LCD_WR     <= 1'b1;
      LCD_RST    <= 1'b0;
      LCD_BL_CTR <= 1'b0;
      LCD_DATA   <= '0;
      init_done  <= 1'b0;
    end else begin
      LCD_CS     <= w_cs_nxt;
      LCD_RS     <= w_rs_nxt;
      LCD_WR     <= w_wr_nxt;
      LCD_RST    <= w_rst_nxt;
      LCD_BL_CTR <= bl_on;
      LCD_DATA   <= w_data_nxt;
      init_done  <= w_init_done_nxt;
    end
  end

endmodule

// File: tb/tb_lcd_bus_sequencer.sv
// tb/tb_lcd_bus_sequencer.sv - randomized scoreboard bench for lcd_bus_sequencer
module tb_lcd_bus_sequencer;
  import lcd_pkg::*;

  localparam int S  = 1;
  localparam int P  = 2;
  localparam int H  = 1;
  localparam int L  = 4;
  localparam int W  = 6;
  localparam int RW = 17;

  logic        HCLK = 1'b0;
  logic        HRESET, init_start, init_done, bl_on, busy;
  logic        LCD_CS, LCD_RS, LCD_WR, LCD_RD, LCD_RST, LCD_BL_CTR;
  logic [15:0] LCD_DATA;

  lcd_bus_sequencer_if #(.REP_W(RW)) req_if ();

  lcd_bus_sequencer #(
    .WR_SETUP(S), .WR_PULSE(P), .WR_HOLD(H),
    .RST_LOW_CYC(L), .RST_WAIT_CYC(W), .REP_W(RW)
  ) dut (
    .HCLK(HCLK), .HRESET(HRESET), .init_start(init_start), .init_done(init_done),
    .req(req_if), .bl_on(bl_on), .busy(busy),
    .LCD_CS(LCD_CS), .LCD_RS(LCD_RS), .LCD_WR(LCD_WR), .LCD_RD(LCD_RD),
    .LCD_RST(LCD_RST), .LCD_BL_CTR(LCD_BL_CTR), .LCD_DATA(LCD_DATA)
  );

  always #5 HCLK = ~HCLK;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  logic [16:0] exp_q[$];
  logic [16:0] mon_word;
  logic        prev_wr = 1'b1;

  always @(posedge HCLK) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Scoreboard monitor: the panel latches a word on each WR rising edge
  always @(negedge HCLK) begin
    if (prev_wr === 1'b0 && LCD_WR === 1'b1) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_write: got 0x%0h with nothing expected (cycle %0d)", {LCD_RS, LCD_DATA}, cyc);
      end else begin
        mon_word = exp_q.pop_front();
        check("write_word", {15'd0, LCD_RS, LCD_DATA}, {15'd0, mon_word});
      end
    end
    if (LCD_WR === 1'b0) check("cs_low_while_wr_low", LCD_CS, 0);
    prev_wr = LCD_WR;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge HCLK);
    #1;
  endtask

  task automatic check_reset_pins(input string tag);
    check({tag, "_cs"},   LCD_CS, 1);
    check({tag, "_rs"},   LCD_RS, 1);
    check({tag, "_wr"},   LCD_WR, 1);
    check({tag, "_rd"},   LCD_RD, 1);
    check({tag, "_rst"},  LCD_RST, 0);
    check({tag, "_bl"},   LCD_BL_CTR, 0);
    check({tag, "_data"}, LCD_DATA, 0);
    check({tag, "_init_done"}, init_done, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_ready"}, req_if.req_ready, 0);
  endtask

  // Present a request from posedge+1; returns at posedge+1 of cycle 1 with valid still high.
  task automatic send(input logic rs, input logic [15:0] d, input int rep, input int npush,
                      output int acc_cyc);
    req_if.req_rs    = rs;
    req_if.req_data  = d;
    req_if.req_rep   = RW'(rep);
    req_if.req_valid = 1'b1;
    acc_cyc = -1;
    for (int n = 0; n < 300; n++) begin
      @(negedge HCLK);
      if (req_if.req_ready === 1'b1) begin
        acc_cyc = cyc;
        break;
      end
    end
    if (acc_cyc < 0) begin
      total++;
      bad++;
      $display("FAIL accept_timeout: got no accept want accept of 0x%0h", d);
    end else begin
      for (int i = 0; i < npush; i++) exp_q.push_back({rs, d});
    end
    tick();
  endtask

  task automatic do_init();
    init_start = 1'b1;
    tick();
    init_start = 1'b0;
    for (int k = 1; k <= L + W + 1; k++) begin
      @(negedge HCLK);
      check("init_lcd_rst", LCD_RST, k > L);
      check("init_done", init_done, k == L + W + 1);
      check("init_busy", busy, k <= L + W);
    end
    tick();
  endtask

  // Single request with cycle-exact pin checks derived from the timing rules
  task automatic timed_write(input logic rs, input logic [15:0] d, input int rep);
    int   n, last, ac, pulses;
    logic pw, exp_wr;
    n = (rep == 0) ? 1 : rep;
    send(rs, d, rep, n, ac);
    req_if.req_valid = 1'b0;
    last   = S + n * (P + H);
    pulses = 0;
    pw     = 1'b1;
    for (int k = 1; k <= last + 1; k++) begin
      @(negedge HCLK);
      exp_wr = !(k > S && k <= last && ((k - S - 1) % (P + H)) < P);
      check("tw_cs", LCD_CS, (k <= last) ? 0 : 1);
      check("tw_wr", LCD_WR, exp_wr);
      if (k <= last) begin
        check("tw_rs", LCD_RS, rs);
        check("tw_data", LCD_DATA, d);
      end
      check("tw_ready", req_if.req_ready, k == last + 1);
      if (pw && !LCD_WR) pulses++;
      pw = LCD_WR;
    end
    check("tw_pulse_count", pulses, n);
    tick();
  endtask

  task automatic drain();
    for (int n = 0; n < 300 && (exp_q.size() != 0 || busy); n++) tick();
    check("drain_queue_empty", exp_q.size(), 0);
    check("drain_not_busy", busy, 0);
  endtask

  int ac, prev_ac, ic, rep, gap, ab_c;
  logic        rs;
  logic [15:0] d;

  initial begin
    HRESET = 1'b1; init_start = 1'b0; bl_on = 1'b0;
    req_if.req_valid = 1'b0; req_if.req_rs = 1'b0; req_if.req_data = '0; req_if.req_rep = '0;
    repeat (3) tick();
    @(negedge HCLK);
    check_reset_pins("reset");
    tick();
    HRESET = 1'b0;

    // UNINIT: a held request is never accepted
    req_if.req_valid = 1'b1; req_if.req_data = 16'h1111;
    for (int k = 0; k < 10; k++) begin
      @(negedge HCLK);
      check("uninit_ready", req_if.req_ready, 0);
      check("uninit_rst", LCD_RST, 0);
      check("uninit_cs", LCD_CS, 1);
    end
    tick();
    req_if.req_valid = 1'b0;

    bl_on = 1'b1;
    tick();
    @(negedge HCLK);
    check("backlight", LCD_BL_CTR, 1);
    tick();

    do_init();

    timed_write(LCD_RS_CMD, LCD_CMD_MEM_WRITE, 1);
    timed_write(LCD_RS_DATA, 16'hF800, 3);
    timed_write(LCD_RS_DATA, 16'h07E0, 0);

    // Back-to-back, valid held: one accept every S+P+H+1 cycles
    prev_ac = 0;
    for (int i = 0; i < 8; i++) begin
      rs  = 1'($urandom_range(0, 1));
      d   = 16'($urandom);
      rep = $urandom_range(0, 1);
      send(rs, d, rep, 1, ac);
      if (i > 0) check("b2b_spacing", ac - prev_ac, S + P + H + 1);
      prev_ac = ac;
    end
    req_if.req_valid = 1'b0;
    drain();

    // Randomized traffic with gaps and repeats
    for (int i = 0; i < 20; i++) begin
      rs  = 1'($urandom_range(0, 1));
      d   = 16'($urandom);
      rep = $urandom_range(0, 4);
      gap = $urandom_range(0, 3);
      send(rs, d, rep, (rep == 0) ? 1 : rep, ac);
      req_if.req_valid = 1'b0;
      repeat (gap) tick();
    end
    drain();

    // init_start beats a same-cycle request in IDLE; the request waits, not dropped
    req_if.req_rs = 1'b1; req_if.req_data = 16'hBEEF; req_if.req_rep = RW'(1);
    req_if.req_valid = 1'b1;
    init_start = 1'b1;
    @(negedge HCLK);
    check("idle_init_wins_ready", req_if.req_ready, 0);
    ic = cyc;
    tick();
    init_start = 1'b0;
    send(1'b1, 16'hBEEF, 1, 1, ac);
    check("idle_init_accept_delay", ac - ic, L + W + 1);
    req_if.req_valid = 1'b0;
    drain();

    // Abort a rep=100 transfer mid-pulse; pulses started before the abort still strobe
    ab_c = 8;
    send(1'b1, 16'hAAAA, 100, (ab_c - S - 1) / (P + H) + 1, ac);
    req_if.req_rs = 1'b0; req_if.req_data = 16'h1234; req_if.req_rep = RW'(1);
    req_if.req_valid = 1'b1;
    repeat (ab_c - 1) tick();
    init_start = 1'b1;
    @(negedge HCLK);
    check("abort_in_pulse_wr", LCD_WR, 0);
    check("abort_ready", req_if.req_ready, 0);
    ic = cyc;
    tick();
    init_start = 1'b0;
    @(negedge HCLK);
    check("abort_cs", LCD_CS, 1);
    check("abort_wr", LCD_WR, 1);
    check("abort_rst", LCD_RST, 0);
    check("abort_init_done", init_done, 0);
    check("abort_busy", busy, 1);
    tick();
    send(1'b0, 16'h1234, 1, 1, ac);
    check("abort_accept_delay", ac - ic, L + W + 1);
    req_if.req_valid = 1'b0;
    drain();

    // HRESET during SETUP: every pin back to its reset value next cycle
    send(1'b1, 16'h5555, 2, 0, ac);
    req_if.req_valid = 1'b0;
    HRESET = 1'b1;
    tick();
    @(negedge HCLK);
    check_reset_pins("midreset");
    tick();
    HRESET = 1'b0;
    repeat (3) tick();
    check("final_queue_empty", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
